// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared definitions for the ALU command controller: command bytes,
// FSM state encoding, ALU watchdog limit and highest legal function code.
package alu_cmd_ctrl_pkg;

    localparam logic [7:0]  CMD_NEW    = 8'hCC;
    localparam logic [7:0]  CMD_REUSE  = 8'hDD;
    localparam int unsigned WDOG_LIMIT = 4;
    localparam int unsigned WDOG_W     = 3;
    localparam int unsigned MAX_FUN    = 14;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_A    = 3'd1,
        GET_B    = 3'd2,
        GET_FUN  = 3'd3,
        ALU_WAIT = 3'd4,
        SEND_LO  = 3'd5,
        SEND_HI  = 3'd6
    } state_t;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command decoder: collects operands and a function code, fires the
// ALU, then streams the two-byte result to the transmitter with a busy handshake.
module alu_cmd_ctrl
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RSLT_WIDTH = 2 * DATA_WIDTH,
    parameter int unsigned FUN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    input  logic [RSLT_WIDTH-1:0] ALU_OUT,
    input  logic                  OUT_VALID,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR
);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [FUN_WIDTH-1:0]    fun_q, fun_d;
    logic [RSLT_WIDTH-1:0]   rslt_q, rslt_d;
    logic [DATA_WIDTH-1:0]   txd_q, txd_d;
    logic                    txv_q, txv_d;
    logic                    en_q, en_d;
    logic                    err_q, err_d;
    logic [WDOG_W-1:0]       wdog_q, wdog_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            rslt_q  <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            rslt_q  <= rslt_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            en_q    <= en_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        rslt_d  = rslt_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        en_d    = 1'b0;
        err_d   = 1'b0;
        wdog_d  = wdog_q;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_WIDTH'(CMD_NEW)) begin
                        state_d = GET_A;
                    end else if (RX_P_DATA == DATA_WIDTH'(CMD_REUSE)) begin
                        state_d = GET_FUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GET_A: begin
                if (RX_D_VLD) begin
                    a_d     = RX_P_DATA;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (RX_D_VLD) begin
                    b_d     = RX_P_DATA;
                    state_d = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_D_VLD) begin
                    // A full-width compare covers both the low-field limit and zero upper bits
                    if (RX_P_DATA <= DATA_WIDTH'(MAX_FUN)) begin
                        fun_d   = RX_P_DATA[FUN_WIDTH-1:0];
                        en_d    = 1'b1;
                        wdog_d  = '0;
                        state_d = ALU_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ALU_WAIT: begin
                if (OUT_VALID) begin
                    rslt_d  = ALU_OUT;
                    txd_d   = ALU_OUT[DATA_WIDTH-1:0];
                    txv_d   = 1'b1;
                    state_d = SEND_LO;
                end else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
            end
            SEND_LO: begin
                if (txv_q && TX_BUSY) begin
                    txv_d   = 1'b0;
                    state_d = SEND_HI;
                end
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
            end
            SEND_HI: begin
                // The high byte is only offered once the transmitter has drained the low byte
                if (txv_q) begin
                    if (TX_BUSY) begin
                        txv_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (!TX_BUSY) begin
                    txd_d = DATA_WIDTH'(rslt_q >> DATA_WIDTH);
                    txv_d = 1'b1;
                end
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign A         = a_q;
    assign B         = b_q;
    assign ALU_FUN   = fun_q;
    assign ALU_EN    = en_q;
    assign TX_P_DATA = txd_q;
    assign TX_D_VLD  = txv_q;
    assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomised bench for alu_cmd_ctrl: a transaction-level model predicts every
// ALU_EN, CMD_ERR and TX byte/valid window, and a per-cycle monitor compares.
module tb_alu_cmd_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 16;
    localparam int unsigned FW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] RX_P_DATA;
    logic          RX_D_VLD;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [FW-1:0] ALU_FUN;
    logic          ALU_EN;
    logic [RW-1:0] ALU_OUT;
    logic          OUT_VALID;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          TX_BUSY;
    logic          CMD_ERR;

    alu_cmd_ctrl #(.DATA_WIDTH(DW), .RSLT_WIDTH(RW), .FUN_WIDTH(FW)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
    } en_exp_t;

    en_exp_t    exp_en[$];
    int         exp_err[$];
    logic [7:0] exp_tx[$];
    bit         exp_vld[int];
    logic [7:0] tx_log[$];

    logic [7:0] m_a, m_b;
    logic [7:0] en_a_obs, en_b_obs;
    logic [3:0] en_f_obs;
    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int err_seen = 0, en_seen = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge CLK) begin : mon
        bit en_x, err_x, vld_x;
        if (!RST) begin
            chk("reset_outputs", {A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 64'd0);
        end else begin
            en_x = (exp_en.size() > 0) && (exp_en[0].c == cyc);
            chk("alu_en", ALU_EN, en_x);
            if (ALU_EN) en_seen++;
            if (en_x) begin
                chk("op_a", A, exp_en[0].a);
                chk("op_b", B, exp_en[0].b);
                chk("alu_fun", ALU_FUN, exp_en[0].f);
                en_a_obs = A;
                en_b_obs = B;
                en_f_obs = ALU_FUN;
                exp_en.delete(0);
            end
            err_x = (exp_err.size() > 0) && (exp_err[0] == cyc);
            chk("cmd_err", CMD_ERR, err_x);
            if (CMD_ERR) err_seen++;
            if (err_x) exp_err.delete(0);
            vld_x = exp_vld.exists(cyc);
            chk("tx_vld", TX_D_VLD, vld_x);
            if (TX_D_VLD && vld_x) begin
                if (exp_tx.size() == 0) begin
                    chk("tx_pending", 0, 1);
                end else begin
                    chk("tx_data", TX_P_DATA, exp_tx[0]);
                    if (TX_BUSY) begin
                        tx_log.push_back(TX_P_DATA);
                        exp_tx.delete(0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_D_VLD = 1'b0;
        repeat (n) tick();
    endtask

    task automatic push_err(input int c);
        if (exp_err.size() == 0 || exp_err[exp_err.size()-1] != c) exp_err.push_back(c);
    endtask

    task automatic send_byte(input logic [7:0] v);
        idle($urandom_range(0, 2));
        RX_P_DATA = v;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    // stray byte while the controller is busy: dropped, flagged next cycle
    task automatic junk(input bit en);
        if (en && $urandom_range(0, 3) == 0) begin
            RX_P_DATA = 8'($urandom);
            RX_D_VLD  = 1'b1;
            push_err(cyc + 1);
        end else begin
            RX_D_VLD = 1'b0;
        end
    endtask

    task automatic run_cmd(input bit reuse, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] fn, input int d, input logic [15:0] res,
                           input int l1, input int h1, input int l2, input int h2,
                           input bit jk, input bit rst_hi);
        if (reuse) begin
            send_byte(8'hDD);
        end else begin
            send_byte(8'hCC);
            send_byte(a);
            m_a = a;
            send_byte(b);
            m_b = b;
        end
        idle($urandom_range(0, 2));
        RX_P_DATA = fn;
        RX_D_VLD  = 1'b1;
        if (fn <= 8'd14) exp_en.push_back('{cyc + 1, m_a, m_b, fn[3:0]});
        else push_err(cyc + 1);
        tick();
        RX_D_VLD = 1'b0;
        if (fn > 8'd14) return;
        for (int i = 0; i < d && i < 4; i++) begin
            junk(jk);
            tick();
        end
        if (d >= 4) begin
            push_err(cyc);
            RX_D_VLD  = 1'b0;
            OUT_VALID = 1'b1;
            ALU_OUT   = res;
            tick();
            OUT_VALID = 1'b0;
            return;
        end
        OUT_VALID = 1'b1;
        ALU_OUT   = res;
        exp_tx.push_back(res[7:0]);
        exp_tx.push_back(res[15:8]);
        junk(jk);
        tick();
        OUT_VALID = 1'b0;
        repeat (l1) begin
            exp_vld[cyc] = 1'b1;
            TX_BUSY = 1'b0;
            junk(jk);
            tick();
        end
        exp_vld[cyc] = 1'b1;
        TX_BUSY = 1'b1;
        junk(jk);
        tick();
        repeat (h1 - 1) begin
            junk(jk);
            tick();
        end
        TX_BUSY = 1'b0;
        junk(jk);
        tick();
        for (int i = 0; i < l2; i++) begin
            exp_vld[cyc] = 1'b1;
            junk(jk);
            if (rst_hi && i == 2) begin
                #2 RST = 1'b0;
                #1;
                chk("rst_async_txvld", TX_D_VLD, 0);
                chk("rst_async_outs", {A, B, ALU_FUN, ALU_EN, TX_P_DATA, CMD_ERR}, 64'd0);
                exp_tx.delete();
                exp_vld.delete();
                exp_en.delete();
                exp_err.delete();
                m_a = 8'h00;
                m_b = 8'h00;
                RX_D_VLD  = 1'b0;
                OUT_VALID = 1'b0;
                TX_BUSY   = 1'b0;
                repeat (2) tick();
                RST = 1'b1;
                return;
            end
            tick();
        end
        exp_vld[cyc] = 1'b1;
        TX_BUSY = 1'b1;
        junk(jk);
        tick();
        RX_D_VLD = 1'b0;
        repeat (h2 - 1) tick();
        TX_BUSY = 1'b0;
    endtask

    task automatic chk_last2(input string name, input logic [7:0] lo, input logic [7:0] hi);
        if (tx_log.size() < 2) begin
            chk(name, tx_log.size(), 2);
        end else begin
            chk({name, "_lo"}, tx_log[tx_log.size()-2], lo);
            chk({name, "_hi"}, tx_log[tx_log.size()-1], hi);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int e0, n0, t0;
        RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = '0; OUT_VALID = 1'b0;
        ALU_OUT = '0; TX_BUSY = 1'b0;
        m_a = 8'h00; m_b = 8'h00;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        idle(2);

        run_cmd(0, 8'h05, 8'h03, 8'h00, 1, 16'h0008, 0, 1, 0, 1, 0, 0);
        idle(2);
        chk("cmd1_a", en_a_obs, 8'h05);
        chk("cmd1_b", en_b_obs, 8'h03);
        chk("cmd1_fun", en_f_obs, 4'h0);
        chk_last2("cmd1_tx", 8'h08, 8'h00);

        run_cmd(1, 8'h00, 8'h00, 8'h0D, 1, 16'h0002, 1, 2, 1, 1, 0, 0);
        idle(2);
        chk("reuse_a", en_a_obs, 8'h05);
        chk("reuse_fun", en_f_obs, 4'hD);
        chk_last2("reuse_tx", 8'h02, 8'h00);

        run_cmd(0, 8'hFF, 8'hFF, 8'h02, 2, 16'hFE01, 10, 1, 10, 2, 0, 0);
        idle(2);
        chk_last2("mul_tx", 8'h01, 8'hFE);

        e0 = err_seen; n0 = en_seen;
        run_cmd(0, 8'h01, 8'h02, 8'h0F, 1, 16'h0000, 0, 1, 0, 1, 0, 0);
        idle(2);
        chk("badfun_err", err_seen - e0, 1);
        chk("badfun_noen", en_seen - n0, 0);
        e0 = err_seen;
        push_err(cyc + 1);
        RX_P_DATA = 8'h55; RX_D_VLD = 1'b1;
        tick();
        idle(2);
        chk("idle_junk_err", err_seen - e0, 1);

        e0 = err_seen; t0 = tx_log.size();
        run_cmd(0, 8'h09, 8'h04, 8'h01, 4, 16'h0005, 0, 1, 0, 1, 0, 0);
        idle(4);
        chk("timeout_err", err_seen - e0, 1);
        chk("timeout_no_tx", tx_log.size() - t0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] fn, j;
            if ($urandom_range(0, 3) == 0) begin
                j = 8'($urandom);
                if (j == 8'hCC || j == 8'hDD) j = 8'h00;
                RX_P_DATA = j;
                RX_D_VLD  = 1'b1;
                push_err(cyc + 1);
                tick();
                RX_D_VLD = 1'b0;
            end
            fn = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(15, 255)) : 8'($urandom_range(0, 14));
            run_cmd($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom), fn,
                    int'($urandom_range(1, 4)), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1, 0);
            chk("tx_drained", exp_tx.size(), 0);
            idle($urandom_range(0, 2));
        end

        run_cmd(0, 8'h11, 8'h22, 8'h03, 1, 16'hABCD, 0, 1, 4, 1, 0, 1);
        idle(6);
        run_cmd(1, 8'h00, 8'h00, 8'h01, 1, 16'h0000, 0, 1, 0, 1, 0, 0);
        idle(2);
        chk("post_rst_a", en_a_obs, 8'h00);
        chk("post_rst_b", en_b_obs, 8'h00);
        chk("post_rst_fun", en_f_obs, 4'h1);
        chk_last2("post_rst_tx", 8'h00, 8'h00);

        idle(3);
        chk("end_en_queue", exp_en.size(), 0);
        chk("end_err_queue", exp_err.size(), 0);
        chk("end_tx_queue", exp_tx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of received bytes, of operands A/B and of transmit bytes.
REQ-002 SHALL have parameter RSLT_WIDTH, default 16: ALU result width, fixed at 2*DATA_WIDTH.
REQ-003 SHALL have parameter FUN_WIDTH, default 4: ALU function-code width.
REQ-004 SHALL have port CLK  input  1  single block clock, all state on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port RX_P_DATA  input  DATA_WIDTH  received byte.
REQ-007 SHALL have port RX_D_VLD  input  1  RX_P_DATA valid, one-cycle pulse per byte.
REQ-008 SHALL have port A, B  output  DATA_WIDTH each  registered ALU operands.
REQ-009 SHALL have port ALU_FUN  output  FUN_WIDTH  registered ALU function code.
REQ-010 SHALL have port ALU_EN  output  1  one-cycle ALU enable pulse.
REQ-011 SHALL have port ALU_OUT  input  RSLT_WIDTH  ALU registered result.
REQ-012 SHALL have port OUT_VALID  input  1  ALU_OUT valid.
REQ-013 SHALL have port TX_P_DATA  output  DATA_WIDTH  byte to transmitter.
REQ-014 SHALL have port TX_D_VLD  output  1  TX_P_DATA valid, held until accepted.
REQ-015 SHALL have port TX_BUSY  input  1  transmitter busy; high marks acceptance.
REQ-016 SHALL have port CMD_ERR  output  1  one-cycle error pulse.

Function
REQ-017 SHALL implement FSM states IDLE, GET_A, GET_B, GET_FUN, ALU_WAIT, SEND_LO, SEND_HI.
REQ-018 IDLE: RX byte 0xCC -> GET_A; 0xDD -> GET_FUN (reuse stored A/B); other byte -> stay IDLE, pulse CMD_ERR.
REQ-019 GET_A / GET_B: on RX_D_VLD capture byte into A / B, advance to GET_B / GET_FUN.
REQ-020 GET_FUN: on RX_D_VLD with byte[FUN_WIDTH-1:0] < 15 and upper bits zero, load ALU_FUN, pulse ALU_EN the same cycle as the ALU_FUN update, go ALU_WAIT; otherwise pulse CMD_ERR, go IDLE, no ALU_EN.
REQ-021 ALU_EN SHALL be high exactly one cycle per accepted command; ALU_FUN, A, B SHALL be stable from that cycle until next command.
REQ-022 ALU_WAIT: on OUT_VALID=1 capture ALU_OUT into result register, go SEND_LO; if OUT_VALID not seen within 4 cycles of entering, pulse CMD_ERR, go IDLE.
REQ-023 SEND_LO: drive TX_P_DATA=result[DATA_WIDTH-1:0], TX_D_VLD=1 while TX_BUSY=0; first cycle TX_BUSY=1 with TX_D_VLD high -> drop TX_D_VLD, go SEND_HI.
REQ-024 SEND_HI: wait TX_BUSY=0, then same handshake with result[RSLT_WIDTH-1:DATA_WIDTH]; on acceptance go IDLE.
REQ-025 TX_D_VLD SHALL never be high outside SEND_LO/SEND_HI; TX_P_DATA SHALL not change while TX_D_VLD=1.
REQ-026 RX_D_VLD in ALU_WAIT, SEND_LO, SEND_HI SHALL be dropped and pulse CMD_ERR; state unaffected.
REQ-027 Minimum latency: ALU_EN in cycle N, OUT_VALID in N+1, TX_D_VLD first high in N+2.
REQ-028 Arithmetic results wider than RSLT_WIDTH are not handled; result taken as-is.

Reset
REQ-029 RST low SHALL asynchronously force state IDLE; A, B, ALU_FUN, result, TX_P_DATA to 0; ALU_EN, TX_D_VLD, CMD_ERR to 0.
REQ-030 Reset mid-frame or mid-send SHALL abandon the command; no further TX_D_VLD until a new complete command.
REQ-031 First command after reset using 0xDD SHALL operate on A=B=0.

Structure
REQ-032 Command codes 0xCC/0xDD, FSM state encoding, watchdog limit 4 and max valid function code 14 SHALL live in the shared system package.
REQ-033 SHALL be a single module; no sub-module.

Verification
REQ-034 0xCC,0x05,0x03,0x00 -> ALU_EN one pulse with A=5,B=3,ALU_FUN=0; ALU_OUT=0x0008 -> TX bytes 0x08 then 0x00.
REQ-035 0xCC,0xFF,0xFF,0x02 -> ALU_OUT=0xFE01 -> TX 0x01 then 0xFE; TX_D_VLD held 10 cycles while TX_BUSY held low, then released on acceptance.
REQ-036 0xDD,0x0D after REQ-034 -> A=5 reused, ALU_FUN=13; ALU_OUT=0x0002 -> TX 0x02,0x00.
REQ-037 0xCC,0x01,0x02,0x0F -> CMD_ERR pulse, no ALU_EN, FSM IDLE; byte 0x55 in IDLE -> CMD_ERR.
REQ-038 OUT_VALID held low after ALU_EN -> CMD_ERR 4 cycles later, no TX; RST low during SEND_HI -> TX_D_VLD low immediately, all outputs 0.
